// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue.
// Issues sequential word-aligned fetch addresses to a variable-latency,
// in-order instruction memory over a request/grant port, buffers responses
// together with their PCs in a DEPTH-entry FIFO and hands them to the fetch
// stage under valid/ready. A redirect empties the FIFO, restarts fetching at
// the new PC and marks every outstanding request as to-be-discarded.
// Optional feature macro: PREFETCH_BYPASS_EN -- a response arriving while the
// FIFO is empty is presented to the fetch stage in the same cycle.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_gnt,
  input  logic                         imem_rvalid,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         fetch_valid,
  output logic [31:0]                  fetch_instr,
  output logic [31:0]                  fetch_pc,
  input  logic                         fetch_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // Architectural state
  logic [31:0]   next_pc_r;
  logic [31:0]   resp_pc_r;
  logic [31:0]   pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] discard_r;

  // Per-cycle decode
  logic [CW-1:0] live_s;
  logic [CW:0]   used_s;
  logic          credit_s;
  logic          grant_s;
  logic          resp_s;
  logic          drop_s;
  logic          keep_s;
  logic          pop_s;
  logic          push_s;
  logic          bypass_take_s;
  logic [CW-1:0] infl_after_resp_s;
  logic [31:0]   redirect_target_s;

  // Credit check: never have more requests outstanding than the FIFO can absorb
  always_comb begin
    live_s            = inflight_r - discard_r;
    used_s            = {1'b0, live_s} + {1'b0, count_r};
    credit_s          = (inflight_r < DEPTH_C) && (used_s < {1'b0, DEPTH_C});
    imem_req          = reset & ~redirect & credit_s;
    imem_addr         = next_pc_r;
    grant_s           = imem_req & imem_gnt;
    resp_s            = imem_rvalid & (inflight_r != ZERO_C);
    drop_s            = resp_s & (discard_r != ZERO_C);
    keep_s            = resp_s & (discard_r == ZERO_C) & ~redirect;
    infl_after_resp_s = inflight_r - {{(CW-1){1'b0}}, resp_s};
    redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
    occupancy         = count_r;
  end

  // Fetch-side view of the head entry (or the bypassed response) and FIFO push/pop
  always_comb begin
    fetch_valid   = 1'b0;
    fetch_instr   = NOP;
    fetch_pc      = 32'h0000_0000;
    bypass_take_s = 1'b0;
    if (redirect) begin
      fetch_valid = 1'b0;
      fetch_instr = NOP;
      fetch_pc    = 32'h0000_0000;
    end else if (count_r != ZERO_C) begin
      fetch_valid = 1'b1;
      fetch_instr = instr_mem_r[rd_ptr_r];
      fetch_pc    = pc_mem_r[rd_ptr_r];
`ifdef PREFETCH_BYPASS_EN
    end else if (keep_s) begin
      fetch_valid   = 1'b1;
      fetch_instr   = imem_rdata;
      fetch_pc      = resp_pc_r;
      bypass_take_s = fetch_ready;
`endif
    end else begin
      fetch_valid = 1'b0;
      fetch_instr = NOP;
      fetch_pc    = 32'h0000_0000;
    end
    pop_s  = fetch_valid & fetch_ready & (count_r != ZERO_C);
    push_s = keep_s & ~bypass_take_s;
  end

  // Sequential state: redirect overrides grants, pushes and pops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_pc_r  <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_C;
      inflight_r <= ZERO_C;
      discard_r  <= ZERO_C;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 32'h0000_0000;
        instr_mem_r[i] <= 32'h0000_0000;
      end
    end else if (redirect) begin
      next_pc_r  <= redirect_target_s;
      resp_pc_r  <= redirect_target_s;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_C;
      inflight_r <= infl_after_resp_s;
      discard_r  <= infl_after_resp_s;
    end else begin
      if (grant_s) begin
        next_pc_r <= next_pc_r + 32'd4;
      end
      if (keep_s) begin
        resp_pc_r <= resp_pc_r + 32'd4;
      end
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= resp_pc_r;
        instr_mem_r[wr_ptr_r] <= imem_rdata;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
      inflight_r <= infl_after_resp_s + {{(CW-1){1'b0}}, grant_s};
      if (drop_s) begin
        discard_r <= discard_r - ONE_C;
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: a queue-based reference model
// plus an in-order variable-latency memory model, compared every cycle, and
// directed scenarios pinned with hand-computed PCs and words.
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .occupancy(occupancy)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ent_t  m_q[$];     // model FIFO contents
  ent_t  log_q[$];   // instructions the DUT handed to fetch
  mreq_t mem_q[$];   // granted, not yet answered memory requests

  logic [31:0] m_next, m_resp;
  int          m_infl, m_disc;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  int max_occ = 0;
  logic gnt_v = 1'b1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    mem_q.delete();
    m_next = 32'h0;
    m_resp = 32'h0;
    m_infl = 0;
    m_disc = 0;
  endtask

  // Asserts reset asynchronously, checks the reset outputs, releases at posedge+1
  task automatic do_reset();
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    fetch_ready = 1'b0;
    reset       = 1'b0;
    model_reset();
    #1;
    check32("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check32("rst_imem_addr", imem_addr, 32'h0000_0000);
    check32("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
    check32("rst_fetch_instr", fetch_instr, 32'h0000_0013);
    check32("rst_fetch_pc", fetch_pc, 32'h0);
    check32("rst_occupancy", {29'h0, occupancy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model
  task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic        e_req, e_valid, resp, keep, bt;
    logic [31:0] e_instr, e_pc;
    fetch_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = gnt_v;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #2;
    e_req = !rd && (m_infl < DEPTH) && ((m_infl - m_disc + m_q.size()) < DEPTH);
    resp  = imem_rvalid && (m_infl > 0);
    keep  = resp && (m_disc == 0) && !rd;
    e_valid = 1'b0;
    e_instr = 32'h0000_0013;
    e_pc    = 32'h0;
    if (!rd && m_q.size() > 0) begin
      e_valid = 1'b1;
      e_instr = m_q[0].instr;
      e_pc    = m_q[0].pc;
    end
`ifdef PREFETCH_BYPASS_EN
    else if (keep) begin
      e_valid = 1'b1;
      e_instr = word_of(m_resp);
      e_pc    = m_resp;
    end
`endif
    check32("imem_req", {31'h0, imem_req}, {31'h0, e_req});
    if (e_req) check32("imem_addr", imem_addr, m_next);
    check32("fetch_valid", {31'h0, fetch_valid}, {31'h0, e_valid});
    check32("fetch_instr", fetch_instr, e_instr);
    check32("fetch_pc", fetch_pc, e_pc);
    check32("occupancy", {29'h0, occupancy}, m_q.size());
    if (occupancy > max_occ) max_occ = occupancy;
    if (fetch_valid && rdy) log_q.push_back('{fetch_pc, fetch_instr});
    if (imem_req && gnt_v) mem_q.push_back('{imem_addr, cyc + lat});
    if (rd) begin
      m_q.delete();
      m_next = rpc & 32'hFFFF_FFFC;
      m_resp = rpc & 32'hFFFF_FFFC;
      if (resp) m_infl--;
      m_disc = m_infl;
    end else begin
      bt = 1'b0;
      if (e_valid && rdy) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else bt = 1'b1;
      end
      if (resp) begin
        if (m_disc > 0) m_disc--;
        else begin
          if (!bt) m_q.push_back('{m_resp, word_of(m_resp)});
          m_resp = m_resp + 32'd4;
        end
        m_infl--;
      end
      if (e_req && gnt_v) begin
        m_next = m_next + 32'd4;
        m_infl++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // T1: streaming, single-cycle memory, fetch always ready
    do_reset();
    gnt_v = 1'b1; lat = 1; log_q.delete(); max_occ = 0;
    repeat (2) cycle(1'b1, 1'b0, 32'h0);
`ifdef PREFETCH_BYPASS_EN
    check32("t1_startup_pops", log_q.size(), 32'd1);
`else
    check32("t1_startup_pops", log_q.size(), 32'd0);
`endif
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    check32("t1_pop_count", {31'h0, log_q.size() >= 8}, 32'h1);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check32("t1_pc_seq", log_q[i].pc, 32'(i * 4));
      check32("t1_instr_seq", log_q[i].instr, 32'(i * 4) ^ 32'hDEAD_0000);
    end
`ifdef PREFETCH_BYPASS_EN
    check32("t1_max_occ", max_occ, 32'd0);
`else
    check32("t1_max_occ", max_occ, 32'd1);
`endif

    // T2: stalled fetch fills the queue, then drains in order
    do_reset();
    log_q.delete();
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    check32("t2_occ_full", {29'h0, occupancy}, 32'd4);
    check32("t2_req_low", {31'h0, imem_req}, 32'h0);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    check32("t2_drained", {31'h0, log_q.size() >= 4}, 32'h1);
    if (log_q.size() >= 4) begin
      check32("t2_pc0", log_q[0].pc, 32'h0000_0000);
      check32("t2_pc1", log_q[1].pc, 32'h0000_0004);
      check32("t2_pc2", log_q[2].pc, 32'h0000_0008);
      check32("t2_pc3", log_q[3].pc, 32'h0000_000C);
      check32("t2_instr3", log_q[3].instr, 32'hDEAD_000C);
    end

    // T3: three requests in flight at latency 5, then redirect
    do_reset();
    lat = 5; log_q.delete();
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0100);
    n = 0;
    while (log_q.size() == 0 && n < 40) begin
      cycle(1'b1, 1'b0, 32'h0);
      n++;
    end
    check32("t3_pop_seen", {31'h0, log_q.size() > 0}, 32'h1);
    if (log_q.size() > 0) begin
      check32("t3_first_pc", log_q[0].pc, 32'h0000_0100);
      check32("t3_first_instr", log_q[0].instr, 32'hDEAD_0100);
    end

    // T4: redirect in the same cycle as a response, fetch ready
    do_reset();
    lat = 1; log_q.delete();
    repeat (5) cycle(1'b1, 1'b0, 32'h0);
    n = log_q.size();
    cycle(1'b1, 1'b1, 32'h0000_0203);
    check32("t4_no_pop", log_q.size(), n);
    redirect = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check32("t4_valid_after", {31'h0, fetch_valid}, 32'h0);
    check32("t4_req_after", {31'h0, imem_req}, 32'h1);
    check32("t4_addr_after", imem_addr, 32'h0000_0200);
    #1;

    // T5: address wrap-around
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    log_q.delete();
    n = 0;
    while (log_q.size() < 4 && n < 30) begin
      cycle(1'b1, 1'b0, 32'h0);
      n++;
    end
    check32("t5_pops", {31'h0, log_q.size() >= 4}, 32'h1);
    if (log_q.size() >= 4) begin
      check32("t5_pc0", log_q[0].pc, 32'hFFFF_FFF8);
      check32("t5_pc1", log_q[1].pc, 32'hFFFF_FFFC);
      check32("t5_pc2", log_q[2].pc, 32'h0000_0000);
      check32("t5_pc3", log_q[3].pc, 32'h0000_0004);
    end

    // T6: mixed traffic with a reset mid-transaction
    for (int k = 0; k < 400; k++) begin
      gnt_v = ($urandom_range(0, 3) != 0);
      lat   = $urandom_range(1, 6);
      if (k == 200) do_reset();
      cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
            $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
